// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: shared ALU opcodes, step states, opcode classes and IR field layout for Mini SRC sequencers
package src_ctrl_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_NOT  = 4;
  localparam int OP_MUL  = 5;
  localparam int OP_DIV  = 6;
  localparam int OP_ROL  = 7;
  localparam int OP_ROR  = 8;
  localparam int OP_SHR  = 9;
  localparam int OP_SHRA = 10;
  localparam int OP_SHL  = 11;
  localparam int OP_NEG  = 12;
  // register fields follow the opcode field, MSB first: ra, rb, rc
  localparam int RF_W   = 4;
  localparam int OFF_RA = 0;
  localparam int OFF_RB = RF_W;
  localparam int OFF_RC = 2 * RF_W;
  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_DONE
  } state_e;
  typedef enum logic [1:0] {CL_BIN, CL_UN, CL_HILO, CL_ILL} op_class_e;
  function automatic op_class_e classify(input int op);
    return (op == OP_NOT || op == OP_NEG) ? CL_UN :
           (op == OP_MUL || op == OP_DIV) ? CL_HILO :
           (op >= OP_ADD && op <= OP_NEG) ? CL_BIN : CL_ILL;
  endfunction
endpackage

// File: rtl/src_op_decode.sv
// src_op_decode: combinational IR decode into opcode class, register fields and illegal flag
//   in : i_ir          instruction register contents
//   out: o_cls, o_op   opcode class and raw opcode field
//        o_ra/o_rb/o_rc register fields, o_div divide flag, o_illegal_op undefined op or register
module src_op_decode
  import src_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int OPW   = 5
) (
  input  logic [WIDTH-1:0] i_ir,
  output op_class_e        o_cls,
  output logic [OPW-1:0]   o_op,
  output logic [RF_W-1:0]  o_ra,
  output logic [RF_W-1:0]  o_rb,
  output logic [RF_W-1:0]  o_rc,
  output logic             o_div,
  output logic             o_illegal_op
);
  localparam int FB = WIDTH - 1 - OPW;
  logic w_bad_reg;
  logic w_unused;
  assign o_op  = i_ir[WIDTH-1 -: OPW];
  assign o_ra  = i_ir[FB - OFF_RA -: RF_W];
  assign o_rb  = i_ir[FB - OFF_RB -: RF_W];
  assign o_rc  = i_ir[FB - OFF_RC -: RF_W];
  assign o_cls = classify(int'(o_op));
  assign o_div = int'(o_op) == OP_DIV;
  // rc only matters for the three-register binary form
  assign w_bad_reg = int'(o_ra) >= NREG || int'(o_rb) >= NREG ||
                     (o_cls == CL_BIN && int'(o_rc) >= NREG);
  assign o_illegal_op = o_cls == CL_ILL || w_bad_reg;
  assign w_unused = ^i_ir[FB - 3 * RF_W:0];
endmodule

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: hardwired Mini SRC control-step sequencer for register-register ALU ops
//   in : w_clock, w_clear (sync active-high), start, mem_ready, ir
//   out: busy/done/illegal status, bus selects s_*, load enables e_*,
//        gpr_rd_sel/gpr_wr_sel, w_IncPC/w_read strobes, opcode to the ALU
module alu_step_sequencer
  import src_ctrl_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NREG       = 16,
  parameter  int DIV_CYCLES = 4,
  parameter  int OPW        = 5,
  localparam int RW         = $clog2(NREG)
) (
  input  logic             w_clock,
  input  logic             w_clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] ir,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             s_PC,
  output logic             s_Zlow,
  output logic             s_Zhigh,
  output logic             s_MDR,
  output logic             s_GPR,
  output logic [RW-1:0]    gpr_rd_sel,
  output logic             e_MAR,
  output logic             e_Z,
  output logic             e_PC,
  output logic             e_MDR,
  output logic             e_IR,
  output logic             e_Y,
  output logic             e_HI,
  output logic             e_LO,
  output logic             e_alu,
  output logic             e_GPR,
  output logic [RW-1:0]    gpr_wr_sel,
  output logic             w_IncPC,
  output logic             w_read,
  output logic [OPW:0]     opcode
);
  localparam int CW = DIV_CYCLES > 0 ? $clog2(DIV_CYCLES + 1) : 1;
  state_e          r_state;
  logic            r_first;
  logic            r_illegal;
  logic [CW-1:0]   r_cnt;
  op_class_e       w_cls;
  logic [OPW-1:0]  w_op;
  logic [RF_W-1:0] w_ra;
  logic [RF_W-1:0] w_rb;
  logic [RF_W-1:0] w_rc;
  logic            w_div;
  logic            w_ill;
  logic            w_last;
  src_op_decode #(.WIDTH(WIDTH), .NREG(NREG), .OPW(OPW)) u_dec (
    .i_ir(ir),
    .o_cls(w_cls),
    .o_op(w_op),
    .o_ra(w_ra),
    .o_rb(w_rb),
    .o_rc(w_rc),
    .o_div(w_div),
    .o_illegal_op(w_ill)
  );
  // divide holds T4 until the counter reaches DIV_CYCLES; other ops leave T4 at once
  assign w_last = !w_div || r_cnt == CW'(DIV_CYCLES);
  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      r_state   <= ST_IDLE;
      r_first   <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_first <= r_state == ST_T0;
      r_cnt   <= r_state == ST_T4 ? r_cnt + 1'b1 : '0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state   <= ST_T0;
          r_illegal <= 1'b0;
        end
        ST_T0: r_state <= ST_T1;
        ST_T1: if (mem_ready) r_state <= ST_T2;
        ST_T2: r_state <= ST_T3;
        ST_T3: if (w_ill) begin
          r_state   <= ST_DONE;
          r_illegal <= 1'b1;
        end else r_state <= ST_T4;
        ST_T4: if (w_last) r_state <= ST_T5;
        ST_T5: r_state <= w_cls == CL_HILO ? ST_T6 : ST_DONE;
        ST_T6: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign busy    = r_state != ST_IDLE && r_state != ST_DONE;
  assign done    = r_state == ST_DONE;
  assign illegal = r_illegal;
  assign s_PC    = r_state == ST_T0;
  assign e_MAR   = r_state == ST_T0;
  assign w_IncPC = r_state == ST_T0;
  assign e_Z     = r_state == ST_T0 || (r_state == ST_T4 && w_last);
  assign s_Zlow  = r_state == ST_T1 || r_state == ST_T5;
  // PC takes Z only once even when T1 is stretched by a slow memory
  assign e_PC    = r_state == ST_T1 && r_first;
  assign w_read  = r_state == ST_T1;
  assign e_MDR   = r_state == ST_T1;
  assign s_MDR   = r_state == ST_T2;
  assign e_IR    = r_state == ST_T2;
  assign e_Y     = r_state == ST_T3 && !w_ill && w_cls != CL_UN;
  assign e_alu   = r_state == ST_T4;
  assign s_GPR   = e_Y || e_alu;
  assign gpr_rd_sel = e_Y   ? RW'(w_cls == CL_BIN ? w_rb : w_ra) :
                      e_alu ? RW'(w_cls == CL_BIN ? w_rc : w_rb) : '0;
  assign opcode  = e_alu ? {1'b0, w_op} : '0;
  assign e_GPR   = r_state == ST_T5 && w_cls != CL_HILO;
  assign gpr_wr_sel = e_GPR ? RW'(w_ra) : '0;
  assign e_LO    = r_state == ST_T5 && w_cls == CL_HILO;
  assign s_Zhigh = r_state == ST_T6;
  assign e_HI    = r_state == ST_T6;
  a_one_bus_driver: assert property (@(posedge w_clock)
    $onehot0({s_PC, s_Zlow, s_Zhigh, s_MDR, s_GPR}));
endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb_alu_step_sequencer: scoreboard bench driving a small Mini SRC datapath model from the sequencer strobes
module tb_alu_step_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        w_clear, start, mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic        s_PC, s_Zlow, s_Zhigh, s_MDR, s_GPR;
  logic [3:0]  gpr_rd_sel, gpr_wr_sel;
  logic        e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu, e_GPR;
  logic        w_IncPC, w_read;
  logic [5:0]  opcode;
  logic [33:0] all_out;
  alu_step_sequencer #(.WIDTH(32), .NREG(16), .DIV_CYCLES(4), .OPW(5)) dut (
    .w_clock(clk), .w_clear(w_clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal),
    .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR), .s_GPR(s_GPR),
    .gpr_rd_sel(gpr_rd_sel),
    .e_MAR(e_MAR), .e_Z(e_Z), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR), .e_Y(e_Y),
    .e_HI(e_HI), .e_LO(e_LO), .e_alu(e_alu), .e_GPR(e_GPR),
    .gpr_wr_sel(gpr_wr_sel), .w_IncPC(w_IncPC), .w_read(w_read), .opcode(opcode)
  );
  assign all_out = {busy, done, illegal, s_PC, s_Zlow, s_Zhigh, s_MDR, s_GPR, gpr_rd_sel,
                    e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu, e_GPR,
                    gpr_wr_sel, w_IncPC, w_read, opcode};
  logic [31:0] R [16] = '{32'h0, 32'h0, 32'h12, 32'h18, 32'h10000, 32'h10000, 32'h0,
                          32'hF0000012, 32'd100, 32'd7, 32'h55, 32'h0, 32'h0, 32'h0,
                          32'h0, 32'h0};
  logic [31:0] PC = '0, MAR = '0, MDR = '0, IR = '0, Y = '0, HI = '0, LO = '0;
  logic [63:0] Z = '0;
  logic [31:0] mem_word, bus;
  logic [63:0] alu;
  function automatic logic [63:0] alu_f(input logic [5:0] op, input logic [31:0] y, input logic [31:0] b);
    case (op)
      6'd0:  return {32'b0, y + b};
      6'd1:  return {32'b0, y - b};
      6'd2:  return {32'b0, y & b};
      6'd3:  return {32'b0, y | b};
      6'd4:  return {32'b0, ~b};
      6'd5:  return {32'b0, y} * {32'b0, b};
      6'd6:  return b == 0 ? 64'b0 : {y % b, y / b};
      6'd7:  return {32'b0, (y << b[4:0]) | (y >> (6'd32 - {1'b0, b[4:0]}))};
      6'd8:  return {32'b0, (y >> b[4:0]) | (y << (6'd32 - {1'b0, b[4:0]}))};
      6'd9:  return {32'b0, y >> b};
      6'd10: return {32'b0, $signed(y) >>> b};
      6'd11: return {32'b0, y << b};
      6'd12: return {32'b0, -b};
      default: return 64'b0;
    endcase
  endfunction
  always_comb begin
    bus = s_PC ? PC : s_Zlow ? Z[31:0] : s_Zhigh ? Z[63:32] : s_MDR ? MDR : s_GPR ? R[gpr_rd_sel] : 32'b0;
    alu = alu_f(opcode, Y, bus);
  end
  always @(posedge clk) begin
    if (e_MAR) MAR <= bus;
    if (e_PC) PC <= bus;
    if (e_MDR && w_read && mem_ready) MDR <= mem_word;
    if (e_IR) IR <= bus;
    if (e_Y) Y <= bus;
    if (e_Z) Z <= e_alu ? alu : {32'b0, bus + (w_IncPC ? 32'd1 : 32'd0)};
    if (e_LO) LO <= bus;
    if (e_HI) HI <= bus;
    if (e_GPR) R[gpr_wr_sel] <= bus;
  end
  assign ir = IR;
  typedef struct {
    string nm;
    int cyc, n_epc, n_ey, n_ez, n_alu, n_gpr, n_lo, n_hi;
    bit ill;
    int op, rd4, r1, r2;
    logic [31:0] v1, v2;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int c_busy = 0, c_epc = 0, c_ey = 0, c_ez = 0, c_alu = 0, c_gpr = 0, c_lo = 0, c_hi = 0;
  int s_op = 0, s_rd = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask
  function automatic logic [31:0] rv(input int i);
    return i == 16 ? LO : i == 17 ? HI : R[i[3:0]];
  endfunction
  task automatic push_exp(input string nm, input int cyc, input int n_ey, input int n_ez,
                          input int n_alu, input int n_gpr, input int n_lo, input int n_hi,
                          input bit ill, input int op, input int rd4,
                          input int r1, input logic [31:0] v1, input int r2, input logic [31:0] v2);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.n_epc = 1; e.n_ey = n_ey; e.n_ez = n_ez; e.n_alu = n_alu;
    e.n_gpr = n_gpr; e.n_lo = n_lo; e.n_hi = n_hi; e.ill = ill; e.op = op; e.rd4 = rd4;
    e.r1 = r1; e.v1 = v1; e.r2 = r2; e.v2 = v2;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        c_busy++;
        c_epc += e_PC ? 1 : 0; c_ey += e_Y ? 1 : 0; c_ez += e_Z ? 1 : 0;
        c_alu += e_alu ? 1 : 0; c_gpr += e_GPR ? 1 : 0; c_lo += e_LO ? 1 : 0; c_hi += e_HI ? 1 : 0;
        if (e_alu) begin s_op = int'(opcode); s_rd = int'(gpr_rd_sel); end
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending instruction");
        end else begin
          e = q.pop_front();
          chk({e.nm, "_done_cycle"}, c_busy + 1, e.cyc);
          chk({e.nm, "_ePC_cycles"}, c_epc, e.n_epc);
          chk({e.nm, "_eY_cycles"}, c_ey, e.n_ey);
          chk({e.nm, "_eZ_cycles"}, c_ez, e.n_ez);
          chk({e.nm, "_ealu_cycles"}, c_alu, e.n_alu);
          chk({e.nm, "_eGPR_cycles"}, c_gpr, e.n_gpr);
          chk({e.nm, "_eLO_cycles"}, c_lo, e.n_lo);
          chk({e.nm, "_eHI_cycles"}, c_hi, e.n_hi);
          chk({e.nm, "_illegal"}, illegal, e.ill);
          if (e.n_alu > 0) begin
            chk({e.nm, "_T4_opcode"}, s_op, e.op);
            chk({e.nm, "_T4_rd_sel"}, s_rd, e.rd4);
          end
          if (e.r1 >= 0) chk({e.nm, "_result1"}, rv(e.r1), e.v1);
          if (e.r2 >= 0) chk({e.nm, "_result2"}, rv(e.r2), e.v2);
        end
      end
      if (busy !== 1'b1) begin
        c_busy = 0; c_epc = 0; c_ey = 0; c_ez = 0; c_alu = 0; c_gpr = 0; c_lo = 0; c_hi = 0;
      end
    end
  end
  function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'b0};
  endfunction
  task automatic run(input logic [31:0] instr, input int dly, input bit spam);
    int n;
    mem_word = instr;
    mem_ready = dly == 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (w_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (dly) @(negedge clk);
    mem_ready = 1'b1;
    if (spam) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        start = i % 2 == 0;
      end
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done within 60 cycles expected done pulse");
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_start_in_done", busy, 0);
  endtask
  initial begin
    int n;
    w_clear = 1'b1; start = 1'b0; mem_ready = 1'b1; mem_word = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 0);
    w_clear = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_out, 0);
    push_exp("neg", 7, 0, 2, 1, 1, 0, 0, 0, 12, 7, 6, 32'h0FFFFFEE, -1, 0);
    run(enc(12, 6, 7, 0), 0, 0);
    push_exp("add_slowmem", 10, 1, 2, 1, 1, 0, 0, 0, 0, 3, 1, 32'h2A, -1, 0);
    run(enc(0, 1, 2, 3), 3, 0);
    push_exp("mul", 8, 1, 2, 1, 0, 1, 1, 0, 5, 5, 16, 32'h0, 17, 32'h1);
    run(enc(5, 4, 5, 0), 0, 0);
    push_exp("div", 12, 1, 2, 5, 0, 1, 1, 0, 6, 9, 16, 32'd14, 17, 32'd2);
    run(enc(6, 8, 9, 0), 0, 1);
    push_exp("op31", 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, -1, 0, -1, 0);
    run(enc(31, 0, 0, 0), 0, 0);
    chk("illegal_sticky_in_idle", illegal, 1);
    push_exp("add_after_illegal", 7, 1, 2, 1, 1, 0, 0, 0, 0, 3, 12, 32'h2A, -1, 0);
    run(enc(0, 12, 2, 3), 0, 0);
    push_exp("op13", 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, -1, 0, -1, 0);
    run(enc(13, 1, 2, 3), 0, 0);
    push_exp("sub", 7, 1, 2, 1, 1, 0, 0, 0, 1, 2, 11, 32'h6, -1, 0);
    run(enc(1, 11, 3, 2), 0, 0);
    mem_word = enc(0, 10, 2, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (e_alu !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    if (e_alu !== 1'b1) begin
      tests++; fails++;
      $display("FAIL clear_reach_T4: got no e_alu within 30 cycles expected T4");
    end
    w_clear = 1'b1;
    @(negedge clk);
    w_clear = 1'b0;
    chk("clear_outputs", all_out, 0);
    repeat (4) @(negedge clk);
    chk("clear_no_gpr_write", R[10], 32'h55);
    chk("clear_stays_idle", busy, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
- Hardwired control-step sequencer for the Mini SRC datapath.
- It fetches one instruction, decodes its opcode, and drives the DataPath select/enable strobes. Software no longer writes these strobes by hand.
- Covers every register-register ALU op (add..neg), including two-operand, unary and HI/LO-producing forms.
- Adds three things: a memory-ready handshake, a multi-cycle divide stall, and illegal-opcode trapping.
- Parametrised in data width, register count and divide latency.

Parameters:
- WIDTH, 32: datapath/IR width. Must be ≥ 32. Fields sit at the top of the IR.
- NREG, 16: number of GPRs. Register select width RW = clog2(NREG).
- DIV_CYCLES, 4: extra T4 cycles held for div. 0 means a single-cycle divide.
- OPW, 5: opcode field width.

Ports:
- w_clock  in  1  system clock, rising edge
- w_clear  in  1  synchronous active-high reset
- start  in  1  begin fetch/execute of the instruction at PC
- mem_ready  in  1  memory data valid while w_read is high
- ir  in  WIDTH  current IR contents from DataPath
- busy  out  1  high from T0 through T6
- done  out  1  one-cycle pulse after the final step
- illegal  out  1  sticky; set on an undefined opcode, cleared by w_clear or start
- s_PC, s_Zlow, s_Zhigh, s_MDR, s_GPR  out  1 each  bus-driver selects, one-hot or all-zero
- gpr_rd_sel  out  RW  GPR driven onto the bus when s_GPR=1
- e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu, e_GPR  out  1 each  register load enables
- gpr_wr_sel  out  RW  GPR loaded when e_GPR=1
- w_IncPC, w_read  out  1 each  PC increment and memory read strobes
- opcode  out  OPW+1  ALU operation (zero-extended IR opcode)

Behaviour:
- Reset: state=IDLE. All outputs 0, including busy, done and illegal. w_clear overrides any state mid-instruction and returns to IDLE next edge; no strobes are issued that cycle.
- IR decode: op=ir[WIDTH-1 -: OPW], ra=next 4 bits, rb=next 4, rc=next 4. Register indices ≥ NREG set illegal.
- Opcode classes:
  - Binary: add, sub, and, or, rol, ror, shr, shra, shl (0..3, 7..11).
  - Unary: not, neg (4, 12).
  - HI/LO: mul, div (5, 6).
  - Opcodes 13..31 are illegal.
- One state per cycle, all strobes Moore outputs of the state:
  - IDLE: start → T0.
  - T0: s_PC, e_MAR, w_IncPC, e_Z → T1.
  - T1: s_Zlow, e_PC, w_read, e_MDR. Hold T1, with e_PC only in the first T1 cycle, until mem_ready=1 → T2.
  - T2: s_MDR, e_IR → T3.
  - T3: classify op.
    - Illegal: set illegal → DONE.
    - Unary: skip Y, → T4.
    - Binary: s_GPR, gpr_rd_sel=rb, e_Y.
    - HI/LO: s_GPR, gpr_rd_sel=ra, e_Y.
  - T4: s_GPR, gpr_rd_sel = rc (binary) or rb (unary/HI/LO), e_alu, e_Z, opcode=op.
    - div: hold T4 for DIV_CYCLES extra cycles; e_Z is asserted only in the last cycle.
  - T5:
    - Binary/unary: s_Zlow, e_GPR, gpr_wr_sel=ra → DONE.
    - HI/LO: s_Zlow, e_LO → T6.
  - T6: s_Zhigh, e_HI → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start while busy is ignored. start in DONE is ignored; a new instruction needs IDLE.
- At most one bus select is high in any cycle (checked by assertion).
- Latency from start to done: 6 + T1 wait cycles. HI/LO ops add 1 cycle. div adds DIV_CYCLES.

Decomposition:
- Shared package src_ctrl_pkg:
  - ALU opcode constants add..neg (values 0..12).
  - State encoding: IDLE, T0..T6, DONE in 4 bits.
  - Opcode class enum and IR field offsets.
- One natural sub-module: src_op_decode. Combinational; takes ir and produces class, ra/rb/rc and illegal_op. Reused by future load/store/branch sequencers.

Test Plan:
- neg R6,R7 (op=12, ra=6, rb=7), mem_ready tied 1, R7=0xF0000012 → e_alu in T4 with gpr_rd_sel=7, opcode=12. T5 has e_GPR, gpr_wr_sel=6, giving R6=0x0FFFFFEE. done at cycle 7. No e_Y.
- add R1,R2,R3 with R2=0x12, R3=0x18, mem_ready delayed 3 cycles → T1 held 3 extra cycles; e_PC high for only 1 cycle. R1=0x2A; done at cycle 10.
- mul R4,R5 with R4=0x10000, R5=0x10000 → T5 e_LO (LO=0), T6 e_HI (HI=1). No e_GPR; done at cycle 8.
- div with DIV_CYCLES=4 → T4 held 5 cycles, e_Z only in the last. busy stays high throughout; start pulses during busy are ignored.
- Opcode 0x1F → illegal=1 after T3, then DONE. No e_GPR/e_HI/e_LO asserted. The next start clears illegal.
- w_clear asserted in T4 → next cycle IDLE. All strobes 0, busy=0, no GPR write occurs.
